// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//   Groups the serial subtractor's request/result signals into one bundle.
//   The requester side drives the operands and the start strobe.
//   The subtractor side returns the status flags and the result.
//
//   Signals
//     start  request strobe, sampled by the subtractor only while idle
//     A      minuend
//     B      subtrahend
//     Bin    borrow-in
//     busy   operation in progress (BUSY or DONE)
//     done   one-cycle completion pulse
//     Diff   (A - B - Bin) mod 2^WIDTH
//     Bout   borrow-out, set when A < B + Bin
//
//   Modports
//     master  requester side (testbench or datapath controller)
//     slave   subtractor side
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;

  modport master (
    output start,
    output A,
    output B,
    output Bin,
    input  busy,
    input  done,
    input  Diff,
    input  Bout
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    input  Bin,
    output busy,
    output done,
    output Diff,
    output Bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Multi-cycle unsigned subtractor computing Diff = A - B - Bin, DIGIT bits
//   per clock, least-significant digit first.  The borrow between digits is
//   carried in a register, so only a DIGIT-bit borrow chain exists per cycle.
//
//   Operation
//     IDLE : a start request captures A, B and Bin into shift registers.
//     BUSY : N = WIDTH/DIGIT cycles, one digit of the difference per cycle.
//     DONE : one cycle with done=1; Diff/Bout were loaded on entry.
//   The result outputs only change on DONE entry (or reset), so they stay
//   valid while the next operation is running.
//
//   Parameters
//     WIDTH  operand / result width
//     DIGIT  bits processed per cycle; must divide WIDTH (DIGIT==WIDTH legal)
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    serial_subtractor_if.slave (start, A, B, Bin, busy, done,
//            Diff, Bout)
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  // Number of BUSY cycles and width of the digit counter.  The counter keeps
  // at least one bit so the DIGIT==WIDTH (N=1) configuration stays legal.
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
  logic [WIDTH-1:0]   res_q,   res_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   diff_q,  diff_d;
  logic               bout_q,  bout_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  // -------------------------------------------------------------------------
  // Per-digit arithmetic
  // -------------------------------------------------------------------------
  logic [DIGIT-1:0]   a_dig_s;
  logic [DIGIT-1:0]   b_dig_s;
  logic [DIGIT:0]     dig_full_s;   // {borrow-out, digit difference}
  logic [DIGIT-1:0]   dig_s;
  logic               brw_s;
  logic [WIDTH-1:0]   res_nx_s;     // result register after shifting in dig_s

  // Current digit difference with borrow; the extra top bit of the
  // (DIGIT+1)-bit subtraction is the borrow into the next digit.
  always_comb begin
    a_dig_s    = a_sh_q[DIGIT-1:0];
    b_dig_s    = b_sh_q[DIGIT-1:0];
    dig_full_s = {1'b0, a_dig_s} - {1'b0, b_dig_s} - {{DIGIT{1'b0}}, borrow_q};
    dig_s      = dig_full_s[DIGIT-1:0];
    brw_s      = dig_full_s[DIGIT];
    // New digit enters at the top; after N shifts the first (LS) digit has
    // reached bit 0.  Written as shift/or so DIGIT==WIDTH needs no special case.
    res_nx_s   = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
  end

  // Next-state, datapath and output-register logic for the IDLE/BUSY/DONE FSM
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.A;
          b_sh_d   = bus.B;
          borrow_d = bus.Bin;
          res_d    = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_BUSY: begin
        a_sh_d   = a_sh_q >> DIGIT;
        b_sh_d   = b_sh_q >> DIGIT;
        res_d    = res_nx_s;
        borrow_d = brw_s;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Last digit: publish the full result and the final borrow.
          diff_d  = res_nx_s;
          bout_d  = brw_s;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end

      ST_DONE: begin
        // start is deliberately not sampled here; a new request is only
        // accepted once back in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Drive the interface straight from registers
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(8)) bus2 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bout;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [7:0] a,
                       input logic [7:0] b, input logic bin);
    if (sel == 0) begin
      bus2.start = st; bus2.A = a; bus2.B = b; bus2.Bin = bin;
    end else begin
      bus8.start = st; bus8.A = a; bus8.B = b; bus8.Bin = bin;
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? bus2.done : bus8.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus2.busy : bus8.busy;
  endfunction

  // Full operation from IDLE; returns result and edges from start edge to done.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, output logic [7:0] diff, output logic bout,
                        output int lat);
    drive(sel, 1'b1, a, b, bin);
    @(posedge clk); #1;
    // Scramble operands after capture; they must not matter.
    drive(sel, 1'b0, ~a, a ^ 8'h5A, ~bin);
    lat = 99;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (get_done(sel)) begin
        lat = i;
        break;
      end
    end
    if (sel == 0) begin diff = bus2.Diff; bout = bus2.Bout; end
    else          begin diff = bus8.Diff; bout = bus8.Bout; end
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, get_done(sel)}, 32'd0);
    chk("idle_after_done", {31'd0, get_busy(sel)}, 32'd0);
  endtask

  logic [7:0] d;
  logic       bo;
  int         lat;
  int         n_lat;
  logic [8:0] ref9;
  logic [7:0] ra, rb;
  logic       rbin;
  bit         saw_done;

  initial begin
    vecs[0] = '{8'h03, 8'h00, 1'b0, 8'h03, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'hF3, 8'hF3, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hF3, 8'hF3, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h33, 8'h13, 1'b0, 8'h20, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
    vecs[8] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[9] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};

    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy2", {31'd0, bus2.busy}, 32'd0);
    chk("rst_done2", {31'd0, bus2.done}, 32'd0);
    chk("rst_diff2", {24'd0, bus2.Diff}, 32'd0);
    chk("rst_bout2", {31'd0, bus2.Bout}, 32'd0);
    chk("rst_diff8", {24'd0, bus8.Diff}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors on both configurations
    for (int s = 0; s < 2; s++) begin
      n_lat = (s == 0) ? 4 : 1;
      for (int i = 0; i < 10; i++) begin
        run_op(s, vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, lat);
        chk($sformatf("vec%0d_s%0d_diff", i, s), {24'd0, d}, {24'd0, vecs[i].exp_diff});
        chk($sformatf("vec%0d_s%0d_bout", i, s), {31'd0, bo}, {31'd0, vecs[i].exp_bout});
        chk($sformatf("vec%0d_s%0d_lat", i, s), lat, n_lat);
      end
    end

    // Start held high during BUSY/DONE: ignored until back in IDLE
    drive(0, 1'b1, 8'h33, 8'h13, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 8'hFF, 8'h00, 1'b0);
    saw_done = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (bus2.done) saw_done = 1'b1;
      if (i < 4) chk("hold_busy", {31'd0, bus2.busy}, 32'd1);
    end
    chk("hold_done", {31'd0, saw_done}, 32'd1);
    chk("hold_diff1", {24'd0, bus2.Diff}, 32'h20);
    chk("hold_bout1", {31'd0, bus2.Bout}, 32'd0);
    @(posedge clk); #1;
    chk("hold_idle_gap", {31'd0, bus2.busy}, 32'd0);
    @(posedge clk); #1;
    chk("hold_restart", {31'd0, bus2.busy}, 32'd1);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk("hold_diff_stable", {24'd0, bus2.Diff}, 32'h20);
    lat = 99;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus2.done) begin lat = i; break; end
    end
    chk("hold_lat2", lat, 4);
    chk("hold_diff2", {24'd0, bus2.Diff}, 32'hFF);
    chk("hold_bout2", {31'd0, bus2.Bout}, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of BUSY
    drive(0, 1'b1, 8'h55, 8'h11, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus2.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus2.done}, 32'd0);
    chk("mid_rst_diff", {24'd0, bus2.Diff}, 32'd0);
    chk("mid_rst_bout", {31'd0, bus2.Bout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus2.done || bus2.busy) saw_done = 1'b1;
    end
    chk("mid_rst_no_done", {31'd0, saw_done}, 32'd0);
    run_op(0, 8'h11, 8'h13, 1'b1, d, bo, lat);
    chk("post_rst_diff", {24'd0, d}, 32'hFD);
    chk("post_rst_bout", {31'd0, bo}, 32'd1);
    chk("post_rst_lat", lat, 4);

    // Random sweep against the arithmetic reference A - B - Bin
    for (int s = 0; s < 2; s++) begin
      n_lat = (s == 0) ? 4 : 1;
      for (int i = 0; i < 20; i++) begin
        ra   = 8'($urandom_range(0, 255));
        rb   = 8'($urandom_range(0, 255));
        rbin = 1'($urandom_range(0, 1));
        ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
        run_op(s, ra, rb, rbin, d, bo, lat);
        chk($sformatf("rnd_s%0d_%02h_%02h_%0d_diff", s, ra, rb, rbin), {24'd0, d}, {24'd0, ref9[7:0]});
        chk($sformatf("rnd_s%0d_%02h_%02h_%0d_bout", s, ra, rb, rbin), {31'd0, bo}, {31'd0, ref9[8]});
        chk($sformatf("rnd_s%0d_lat", s), lat, n_lat);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
